servo_pwm: RTL and testbench
============================

# servo_pwm

Multi-channel RC servo/ESC pulse generator: the transmit-side counterpart of the radio PWM decoder, using the same 1 MHz timebase and the same 10-bit command scale. Each channel emits one high pulse per frame of width 987 µs + cmd (987–2010 µs). Commands are double-buffered and applied only at frame boundaries, so pulses are never truncated or stretched mid-frame. The block sits between the flight-control logic and the motor/servo output pins.

## Interface
- CHANNELS, 4: number of PWM outputs (1–8).
- FRAME_US, 20000: frame period in clk_1M cycles. Must be > 2010 and < 32768.
- clk_1M  input  1  1 MHz clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- cmd_in  input  10*CHANNELS  commands; channel i at bits [10*i+9 : 10*i]; 0 → 987 µs, 1023 → 2010 µs.
- cmd_valid  input  1  single-cycle strobe; captures all of cmd_in into the shadow register.
- arm  input  1  outputs are enabled for a frame only if arm is high at that frame's start.
- pwm_out  output  CHANNELS  pulse outputs, registered.
- frame_sync  output  1  one-cycle pulse on the first cycle of every frame.
- pending  output  1  high while the shadow holds a command not yet transferred to the active register.

## Operation
- Frame counter ctr: 15 bits, counts 0 … FRAME_US-1, then wraps to 0. The wrap edge is the frame boundary.
- Shadow register (10*CHANNELS bits): loaded from cmd_in on any edge with cmd_valid=1. On that edge, pending is set to 1.
- Active register: loaded from the shadow on each frame-boundary edge, using the shadow value from before that edge. pending clears on that edge, unless cmd_valid is also high on the same edge.
- cmd_valid on the boundary edge updates only the shadow. The new value applies at the next frame, and pending stays 1.
- Armed-frame flag: sampled from arm on each boundary edge and held for the whole frame. Changes to arm mid-frame have no effect until the next boundary.
- Pulse width for channel i: width_i = 987 + active_i, an 11-bit unsigned value in the range 987–2010. It never overflows and never reaches FRAME_US.
- pwm_out[i] is registered. It equals armed_frame AND (ctr < width_i), evaluated on the post-edge values of ctr, width and armed_frame.
- Disarmed frame: all pwm_out held 0 for the whole frame. frame_sync still pulses.

## Timing
- Reset values: ctr = FRAME_US-1, so the first edge after reset release is a boundary.
  - Shadow and active = 0.
  - armed_frame = 0, pwm_out = 0, frame_sync = 0, pending = 0.
- First boundary edge after rst_n rises:
  - ctr → 0 and frame_sync → 1.
  - If arm = 1, pwm_out → 1 on that same edge.
- Pulse length: pwm_out[i] stays high for exactly width_i cycles, then falls. All channels rise together on the same edge; each falls independently.
- frame_sync is high for exactly 1 cycle every FRAME_US cycles.
- Command latency: a cmd_valid at frame cycle k (0 ≤ k ≤ FRAME_US-2) takes effect at the next boundary, i.e. FRAME_US-1-k cycles later. A cmd_valid on cycle FRAME_US-1 is captured on the boundary edge, so it takes effect one full frame later.
- Multiple cmd_valid strobes within one frame: the last one wins.
- Reset mid-frame: all outputs drop to 0 immediately (asynchronous). After release, the timing above restarts from scratch; the command is back to 0.

## Structure
- Shared package pwm_pkg holds:
  - CMD_W = 10
  - PULSE_MIN_US = 987
  - PULSE_MAX_US = 2010
  - CTR_W = 15
  
  These constants are shared with the radio decoder so both ends use one scale.
- Sub-module pwm_channel, instantiated CHANNELS times. It contains the per-channel active register, width adder, compare and output flop, and takes ctr, boundary, armed_frame and the shadow slice as inputs.
- The top level owns ctr, the shadow register, pending, armed_frame and frame_sync.

## Test plan
- Reset, then arm = 1 with no command → all pwm_out rise on the first boundary edge and stay high exactly 987 cycles. frame_sync repeats every 20000 cycles.
- cmd_valid with ch0 = 0, ch1 = 1023, ch2 = 512, ch3 = 13 at frame cycle 100 → in the following frame, widths are 987/2010/1499/1000. pending is high from cycle 101 until the boundary.
- Two cmd_valid strobes in one frame (ch0 = 100, then ch0 = 200), plus a third strobe on cycle FRAME_US-1 (ch0 = 300) → the next frame's width is 1187, the frame after is 1287, and pending is high across the boundary.
- arm drops at cycle 500 of an armed frame → the current pulse completes at its full width. The next frame has pwm_out = 0 with frame_sync still present. Re-arming restores pulses at the following boundary.
- Assert rst_n low at cycle 1200, in the middle of a 2010-cycle pulse → pwm_out goes 0 with no clock edge needed. After release, width returns to 987 and pending = 0.
- Parameter run with CHANNELS = 1 and FRAME_US = 2500 → 1023 produces a 2010-cycle pulse, followed by 490 low cycles per frame.

Source files
------------

// File: rtl/pwm_pkg.sv
// Constants shared by the RC PWM encoder and the radio PWM decoder so both
// ends of the link use one command scale and one timebase.
package pwm_pkg;
    localparam int CMD_W        = 10;
    localparam int PULSE_MIN_US = 987;
    localparam int PULSE_MAX_US = 2010;
    localparam int CTR_W        = 15;
    localparam int WIDTH_W      = 11;

    // Pulse width in microseconds for a 10-bit command; 987 + 1023 fits in 11 bits.
    function automatic logic [WIDTH_W-1:0] pulse_width(input logic [CMD_W-1:0] cmd);
        return WIDTH_W'(PULSE_MIN_US) + {1'b0, cmd};
    endfunction
endpackage

// File: rtl/servo_pwm_if.sv
// Command/status bundle between flight-control logic (master) and the
// servo pulse generator (slave).
interface servo_pwm_if
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4
) ();
    logic [CMD_W*CHANNELS-1:0] cmd_in;
    logic                      cmd_valid;
    logic                      arm;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      frame_sync;
    logic                      pending;

    modport master (
        output cmd_in, cmd_valid, arm,
        input  pwm_out, frame_sync, pending
    );

    modport slave (
        input  cmd_in, cmd_valid, arm,
        output pwm_out, frame_sync, pending
    );
endinterface

// File: rtl/pwm_channel.sv
// One output channel: active command register, width adder, frame compare
// and registered pulse output.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic             clk_1M,
    input  logic             rst_n,
    input  logic [CTR_W-1:0] ctr_nxt,
    input  logic             boundary,
    input  logic             armed_nxt,
    input  logic [CMD_W-1:0] shadow,
    output logic             pwm
);
    logic [CMD_W-1:0]   active_r;
    logic [CMD_W-1:0]   active_nxt_s;
    logic [WIDTH_W-1:0] width_s;
    logic               pwm_nxt_s;
    logic               pwm_r;

    // Output is decided from post-edge counter, command and arm so it rises on the boundary edge itself.
    always_comb begin
        active_nxt_s = active_r;
        if (boundary) begin
            active_nxt_s = shadow;
        end else begin
            active_nxt_s = active_r;
        end
        width_s   = pulse_width(active_nxt_s);
        pwm_nxt_s = armed_nxt & (ctr_nxt < {{(CTR_W-WIDTH_W){1'b0}}, width_s});
    end

    // Active command and output flop.
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= '0;
            pwm_r    <= 1'b0;
        end else begin
            active_r <= active_nxt_s;
            pwm_r    <= pwm_nxt_s;
        end
    end

    assign pwm = pwm_r;
endmodule

// File: rtl/servo_pwm.sv
// Multi-channel RC servo/ESC pulse generator: frame counter, double-buffered
// commands applied at frame boundaries, and per-frame arming.
module servo_pwm
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int FRAME_US = 20000
) (
    input logic        clk_1M,
    input logic        rst_n,
    servo_pwm_if.slave bus
);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(FRAME_US - 1);

    logic [CTR_W-1:0]          ctr_r;
    logic [CTR_W-1:0]          ctr_nxt_s;
    logic                      boundary_s;
    logic [CMD_W*CHANNELS-1:0] shadow_r;
    logic                      pending_r;
    logic                      pending_nxt_s;
    logic                      armed_r;
    logic                      armed_nxt_s;
    logic                      fsync_r;
    logic [CHANNELS-1:0]       pwm_s;

    // Frame sequencing; a strobe on the boundary edge wins over the pending clear.
    always_comb begin
        boundary_s    = (ctr_r == CTR_LAST);
        ctr_nxt_s     = ctr_r;
        armed_nxt_s   = armed_r;
        pending_nxt_s = pending_r;
        if (boundary_s) begin
            ctr_nxt_s   = '0;
            armed_nxt_s = bus.arm;
        end else begin
            ctr_nxt_s   = ctr_r + CTR_W'(1);
            armed_nxt_s = armed_r;
        end
        if (bus.cmd_valid) begin
            pending_nxt_s = 1'b1;
        end else if (boundary_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Counter starts on its last value so the first edge after reset opens a frame.
    always_ff @(posedge clk_1M or negedge rst_n) begin
        if (!rst_n) begin
            ctr_r     <= CTR_LAST;
            shadow_r  <= '0;
            pending_r <= 1'b0;
            armed_r   <= 1'b0;
            fsync_r   <= 1'b0;
        end else begin
            ctr_r     <= ctr_nxt_s;
            pending_r <= pending_nxt_s;
            armed_r   <= armed_nxt_s;
            fsync_r   <= boundary_s;
            if (bus.cmd_valid) begin
                shadow_r <= bus.cmd_in;
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel u_ch (
            .clk_1M    (clk_1M),
            .rst_n     (rst_n),
            .ctr_nxt   (ctr_nxt_s),
            .boundary  (boundary_s),
            .armed_nxt (armed_nxt_s),
            .shadow    (shadow_r[CMD_W*i +: CMD_W]),
            .pwm       (pwm_s[i])
        );
    end

    assign bus.pwm_out    = pwm_s;
    assign bus.frame_sync = fsync_r;
    assign bus.pending    = pending_r;
endmodule

// File: tb/tb_servo_pwm.sv
// Bench for servo_pwm: a short-frame 4-channel instance driven by directed
// vectors, plus a default-parameter instance and a 1-channel 2500-cycle instance.
module tb_servo_pwm;
    localparam int FM = 3000;
    localparam int FS = 2500;
    localparam int FD = 20000;

    logic clk_1M;
    logic rst_n;
    logic rst2_n;
    logic chk_en;

    servo_pwm_if #(.CHANNELS(4)) bm ();
    servo_pwm_if #(.CHANNELS(4)) bd ();
    servo_pwm_if #(.CHANNELS(1)) bs ();

    servo_pwm #(.CHANNELS(4), .FRAME_US(FM)) u_main  (.clk_1M(clk_1M), .rst_n(rst_n),  .bus(bm));
    servo_pwm                                u_dflt  (.clk_1M(clk_1M), .rst_n(rst2_n), .bus(bd));
    servo_pwm #(.CHANNELS(1), .FRAME_US(FS)) u_small (.clk_1M(clk_1M), .rst_n(rst2_n), .bus(bs));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clk_1M = 1'b0;
        forever #5 clk_1M = ~clk_1M;
    end

    // Main-instance model: frame phase from edge count, commands latched at frame starts.
    int         m_n;
    int         m_phase;
    logic [9:0] m_sh [4];
    logic [9:0] m_act[4];
    logic       m_arm;
    logic       m_pend;

    initial begin
        m_n = 0; m_phase = FM - 1; m_arm = 1'b0; m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        forever begin
            @(posedge clk_1M or negedge rst_n);
            if (!rst_n) begin
                m_n = 0; m_phase = FM - 1; m_arm = 1'b0; m_pend = 1'b0;
                for (int i = 0; i < 4; i++) begin m_sh[i] = '0; m_act[i] = '0; end
            end else begin
                m_n     = m_n + 1;
                m_phase = (m_n - 1) % FM;
                if (m_phase == 0) begin
                    for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                    m_arm  = bm.arm;
                    m_pend = 1'b0;
                end
                if (bm.cmd_valid) begin
                    for (int i = 0; i < 4; i++) m_sh[i] = bm.cmd_in[10*i +: 10];
                    m_pend = 1'b1;
                end
            end
        end
    end

    // Edge count for the two free-running instances.
    int n2;
    initial begin
        n2 = 0;
        forever begin
            @(posedge clk_1M or negedge rst2_n);
            if (!rst2_n) n2 = 0;
            else         n2 = n2 + 1;
        end
    end

    // Compare process plus width/period monitors.
    int   cnt_m[4];
    int   last_w[4];
    int   s_hi0, s_hi1, s_lo1, d_hi0, d_nfs;
    int   d_fs[4];
    logic [3:0] exp_m;
    logic       exp_s, exp_d;
    int   ph, fr;

    initial begin
        for (int i = 0; i < 4; i++) begin cnt_m[i] = 0; last_w[i] = -1; d_fs[i] = 0; end
        s_hi0 = 0; s_hi1 = 0; s_lo1 = 0; d_hi0 = 0; d_nfs = 0;
        forever begin
            @(negedge clk_1M);
            if (chk_en) begin
                for (int i = 0; i < 4; i++) exp_m[i] = m_arm && (m_phase < 987 + int'(m_act[i]));
                chk("main_pwm",  bm.pwm_out,    exp_m);
                chk("main_sync", bm.frame_sync, (m_n > 0 && m_phase == 0));
                chk("main_pend", bm.pending,    m_pend);
                if (m_n > 0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_phase == 0) cnt_m[i] = int'(bm.pwm_out[i]);
                        else              cnt_m[i] = cnt_m[i] + int'(bm.pwm_out[i]);
                        if (m_phase == FM - 1) last_w[i] = cnt_m[i];
                    end
                end

                ph = (n2 > 0) ? (n2 - 1) % FS : 0;
                fr = (n2 > 0) ? (n2 - 1) / FS : 0;
                exp_s = (n2 > 0) && (ph < ((fr == 0) ? 987 : 2010));
                chk("small_pwm",  bs.pwm_out,    exp_s);
                chk("small_sync", bs.frame_sync, (n2 > 0 && ph == 0));
                chk("small_pend", bs.pending,    (n2 >= 1 && n2 <= FS));
                if (n2 > 0 && fr == 0) s_hi0 = s_hi0 + int'(bs.pwm_out[0]);
                if (n2 > 0 && fr == 1) begin
                    s_hi1 = s_hi1 + int'(bs.pwm_out[0]);
                    s_lo1 = s_lo1 + int'(!bs.pwm_out[0]);
                end

                ph = (n2 > 0) ? (n2 - 1) % FD : 0;
                exp_d = (n2 > 0) && (ph < 987);
                chk("dflt_pwm",  bd.pwm_out,    {4{exp_d}});
                chk("dflt_sync", bd.frame_sync, (n2 > 0 && ph == 0));
                chk("dflt_pend", bd.pending,    1'b0);
                if (n2 > 0 && (n2 - 1) / FD == 0) d_hi0 = d_hi0 + int'(bd.pwm_out[0]);
                if (bd.frame_sync && d_nfs < 4) begin d_fs[d_nfs] = n2; d_nfs++; end
            end
        end
    end

    // Advance to the cycle where the main frame counter reads k.
    task automatic at_ctr(input int k);
        int guard;
        guard = 0;
        do begin
            @(posedge clk_1M); #2;
            guard++;
        end while (m_phase != k && guard < FM + 5);
        if (m_phase != k) chk("at_ctr_timeout", m_phase, k);
    endtask

    task automatic strobe(input logic [39:0] v);
        bm.cmd_in    = v;
        bm.cmd_valid = 1'b1;
        @(posedge clk_1M); #2;
        bm.cmd_valid = 1'b0;
    endtask

    task automatic chk_widths(input string name, input int w0, input int w1, input int w2, input int w3);
        chk({name, "_ch0"}, last_w[0], w0);
        chk({name, "_ch1"}, last_w[1], w1);
        chk({name, "_ch2"}, last_w[2], w2);
        chk({name, "_ch3"}, last_w[3], w3);
    endtask

    localparam logic [39:0] CMD_A = {10'd13, 10'd512, 10'd1023, 10'd0};

    initial begin
        rst_n = 1'b1; rst2_n = 1'b1; chk_en = 1'b0;
        bm.cmd_in = '0; bm.cmd_valid = 1'b0; bm.arm = 1'b0;
        bd.cmd_in = '0; bd.cmd_valid = 1'b0; bd.arm = 1'b0;
        bs.cmd_in = '0; bs.cmd_valid = 1'b0; bs.arm = 1'b0;
        #1 rst_n = 1'b0; rst2_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk_1M);
        #2;
        chk("reset_pwm",  bm.pwm_out,    4'h0);
        chk("reset_sync", bm.frame_sync, 1'b0);
        chk("reset_pend", bm.pending,    1'b0);

        bm.arm = 1'b1; bd.arm = 1'b1; bs.arm = 1'b1;
        bs.cmd_in = 10'd1023; bs.cmd_valid = 1'b1;
        rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk_1M); #2;
        bs.cmd_valid = 1'b0;
        chk("first_edge_pwm",  bm.pwm_out,    4'hF);
        chk("first_edge_sync", bm.frame_sync, 1'b1);

        // Frame 1: command at cycle 100, pending until the boundary.
        at_ctr(100);
        strobe(CMD_A);
        chk("pend_101", bm.pending, 1'b1);
        at_ctr(FM - 1);
        chk("pend_end", bm.pending, 1'b1);
        at_ctr(0);
        chk_widths("w_nocmd", 987, 987, 987, 987);
        chk("pend_clear", bm.pending, 1'b0);
        at_ctr(0);
        chk_widths("w_cmd", 987, 2010, 1499, 1000);

        // Frame 3: last strobe wins; strobe on the final cycle lands a frame later.
        at_ctr(100);
        strobe({CMD_A[39:10], 10'd100});
        at_ctr(200);
        strobe({CMD_A[39:10], 10'd200});
        at_ctr(FM - 1);
        strobe({CMD_A[39:10], 10'd300});
        chk("pend_across", bm.pending,    1'b1);
        chk("sync_f4",     bm.frame_sync, 1'b1);
        at_ctr(0);
        chk_widths("w_last_wins", 1187, 2010, 1499, 1000);
        chk("pend_f5", bm.pending, 1'b0);
        at_ctr(0);
        chk_widths("w_late", 1287, 2010, 1499, 1000);

        // Frame 6: arm drops mid-frame; pulses finish at full width.
        at_ctr(500);
        bm.arm = 1'b0;
        at_ctr(2009);
        chk("ch1_hi_2009", bm.pwm_out[1], 1'b1);
        at_ctr(2010);
        chk("ch1_lo_2010", bm.pwm_out[1], 1'b0);
        at_ctr(0);
        chk_widths("w_armdrop", 1287, 2010, 1499, 1000);
        chk("disarm_pwm",  bm.pwm_out,    4'h0);
        chk("disarm_sync", bm.frame_sync, 1'b1);
        at_ctr(1000);
        bm.arm = 1'b1;
        at_ctr(0);
        chk_widths("w_disarmed", 0, 0, 0, 0);
        chk("rearm_pwm", bm.pwm_out, 4'hF);
        at_ctr(0);
        chk_widths("w_rearm", 1287, 2010, 1499, 1000);

        // Frame 9: asynchronous reset in the middle of the 2010-cycle pulse.
        at_ctr(1200);
        chk("pre_rst_ch1", bm.pwm_out[1], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm",  bm.pwm_out,    4'h0);
        chk("async_rst_pend", bm.pending,    1'b0);
        chk("async_rst_sync", bm.frame_sync, 1'b0);
        repeat (3) @(posedge clk_1M);
        #2 rst_n = 1'b1;
        at_ctr(0);
        chk("post_rst_pwm",  bm.pwm_out, 4'hF);
        chk("post_rst_pend", bm.pending, 1'b0);
        at_ctr(0);
        chk_widths("w_post_rst", 987, 987, 987, 987);

        // Free-running instances: default frame period and the 2500-cycle run.
        while (n2 < 2 * FD + 100) @(posedge clk_1M);
        #2;
        chk("dflt_w0",      d_hi0,   987);
        chk("dflt_fs0",     d_fs[0], 1);
        chk("dflt_period",  d_fs[1] - d_fs[0], FD);
        chk("small_hi0",    s_hi0,   987);
        chk("small_hi1",    s_hi1,   2010);
        chk("small_lo1",    s_lo1,   490);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
